// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the load/store path.
// Holds the funct3 size/sign codes, the LOAD/STORE opcodes, the LSU state
// encoding and the access legality check.
package riscv_pkg;

    // Load funct3 codes
    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;

    // Store funct3 codes
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    // Major opcodes
    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;

    // Load/store unit FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT_R = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

    // Returns 1 when the access is misaligned or its funct3 is illegal for
    // its direction. Codes 4/5 are legal only for loads (unsigned variants).
    function automatic logic lsu_fault(input logic       we,
                                       input logic [2:0] funct3,
                                       input logic [1:0] addr_lo);
        logic fault_s;
        case (funct3)
            3'd0:    fault_s = 1'b0;
            3'd1:    fault_s = addr_lo[0];
            3'd2:    fault_s = (addr_lo != 2'b00);
            3'd4:    fault_s = we;
            3'd5:    fault_s = we | addr_lo[0];
            default: fault_s = 1'b1;
        endcase
        return fault_s;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Lane alignment for the load/store unit (purely combinational).
// Ports:
//   we, funct3, addr_lo : captured access attributes
//   wdata               : store data (rs2)
//   rdata               : raw memory read word
//   be                  : byte enables for the word access
//   wdata_rep           : lane-replicated store data (0 for loads)
//   rdata_ext           : lane-extracted, sign/zero-extended load data
module lsu_align
    import riscv_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_rep,
    output logic [31:0] rdata_ext
);

    logic [31:0] shifted_s;

    // Bring the addressed lane down to bit 0. A word access only reaches
    // memory when aligned, so the shift is zero for LW.
    assign shifted_s = rdata >> {addr_lo, 3'b000};

    // Byte enables from the access size in funct3[1:0]
    always_comb begin
        be = 4'b0000;
        case (funct3[1:0])
            2'b00:   be = 4'b0001 << addr_lo;
            2'b01:   be = 4'b0011 << {addr_lo[1], 1'b0};
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    // Store data replicated across every lane the size could address
    always_comb begin
        wdata_rep = 32'h0000_0000;
        if (we) begin
            case (funct3[1:0])
                2'b00:   wdata_rep = {4{wdata[7:0]}};
                2'b01:   wdata_rep = {2{wdata[15:0]}};
                2'b10:   wdata_rep = wdata;
                default: wdata_rep = 32'h0000_0000;
            endcase
        end else begin
            wdata_rep = 32'h0000_0000;
        end
    end

    // Load extension for register write-back
    always_comb begin
        rdata_ext = 32'h0000_0000;
        case (funct3)
            LB:      rdata_ext = {{24{shifted_s[7]}}, shifted_s[7:0]};
            LH:      rdata_ext = {{16{shifted_s[15]}}, shifted_s[15:0]};
            LW:      rdata_ext = shifted_s;
            LBU:     rdata_ext = {24'h00_0000, shifted_s[7:0]};
            LHU:     rdata_ext = {16'h0000, shifted_s[15:0]};
            default: rdata_ext = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multicycle load/store unit between the controller and unified memory.
// Accepts one access in IDLE, faults misaligned/illegal accesses without
// touching memory, otherwise issues a word-addressed byte-enabled request,
// waits for grant (and read data for loads) and pulses rsp_valid once.
// Ports:
//   req_*  : controller request (valid/ready, we, funct3, byte addr, wdata)
//   rsp_*  : completion pulse, extended load data, fault flag
//   mem_*  : memory request held until mem_gnt, read data via mem_rvalid
// All outputs come from registers or from the registered state only.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (DATA_W != 32) begin : g_cfg_err
        $error("load_store_unit: DATA_W must be 32");
    end

    lsu_state_e        state_r;
    logic              we_r;
    logic [2:0]        funct3_r;
    logic [ADDR_W-1:0] addr_r;
    logic [DATA_W-1:0] wdata_r;
    logic              rsp_fault_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    logic              req_fault_s;
    logic              issue_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_rep_s;
    logic [31:0]       rdata_ext_s;

    // Legality of the incoming request, registered at accept
    assign req_fault_s = lsu_fault(req_we, req_funct3, req_addr[1:0]);
    assign issue_s     = (state_r == ST_ISSUE);

    lsu_align u_align (
        .we        (we_r),
        .funct3    (funct3_r),
        .addr_lo   (addr_r[1:0]),
        .wdata     (wdata_r),
        .rdata     (mem_rdata),
        .be        (be_s),
        .wdata_rep (wdata_rep_s),
        .rdata_ext (rdata_ext_s)
    );

    // FSM, request capture and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            we_r        <= 1'b0;
            funct3_r    <= 3'd0;
            addr_r      <= '0;
            wdata_r     <= '0;
            rsp_fault_r <= 1'b0;
            rsp_rdata_r <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_r        <= req_we;
                        funct3_r    <= req_funct3;
                        addr_r      <= req_addr;
                        wdata_r     <= req_wdata;
                        rsp_fault_r <= req_fault_s;
                        if (req_fault_s) begin
                            rsp_rdata_r <= '0;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r     <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    // rvalid in this state is ignored, even alongside grant
                    if (mem_gnt) begin
                        if (we_r) begin
                            rsp_rdata_r <= '0;
                            state_r     <= ST_RESP;
                        end else begin
                            state_r     <= ST_WAIT_R;
                        end
                    end
                end
                ST_WAIT_R: begin
                    if (mem_rvalid) begin
                        rsp_rdata_r <= rdata_ext_s;
                        state_r     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    rsp_fault_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready = (state_r == ST_IDLE);
    assign rsp_valid = (state_r == ST_RESP);
    assign rsp_fault = rsp_fault_r;
    assign rsp_rdata = rsp_rdata_r;

    // Memory port: lane data only while the request is presented
    assign mem_req   = issue_s;
    assign mem_we    = issue_s & we_r;
    assign mem_addr  = {addr_r[ADDR_W-1:2], 2'b00};
    assign mem_be    = issue_s ? be_s : 4'b0000;
    assign mem_wdata = issue_s ? wdata_rep_s : 32'h0000_0000;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vectors, a stalled word
// load with stray handshakes, randomized accesses against a reference model,
// and reset in the middle of a load.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0, req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        req_ready, rsp_valid, rsp_fault;
    logic [31:0] rsp_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'd0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_fault(rsp_fault),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata)
    );

    // ---------------- reference model ----------------
    function automatic logic m_fault(logic we, logic [2:0] f3, logic [31:0] addr);
        int nb;
        bit legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (!legal) return 1'b1;
        nb = 1 << f3[1:0];
        return (int'(addr[1:0]) % nb) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [2:0] f3, logic [31:0] addr);
        int nb;
        nb = 1 << f3[1:0];
        return 4'(((1 << nb) - 1) << addr[1:0]);
    endfunction

    function automatic logic [31:0] m_wd(logic we, logic [2:0] f3, logic [31:0] wdata);
        if (!we) return 32'd0;
        if (f3[1:0] == 2'd0) return 32'h0101_0101 * wdata[7:0];
        if (f3[1:0] == 2'd1) return 32'h0001_0001 * wdata[15:0];
        return wdata;
    endfunction

    function automatic logic [31:0] m_rd(logic [2:0] f3, logic [31:0] addr, logic [31:0] rdata);
        logic [31:0] v, b, h;
        v = rdata >> (8 * addr[1:0]);
        b = v & 32'd255;
        h = v & 32'd65535;
        case (f3)
            3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
            3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd2:    return rdata;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic int m_lat(logic we, logic [2:0] f3, logic [31:0] addr, int g, int r);
        if (m_fault(we, f3, addr)) return 1;
        return we ? 2 + g : 3 + g + r;
    endfunction

    // ---------------- access driver (reports observations) ----------------
    // Presents one request, plays memory with gdly grant stalls and rdly rvalid
    // stalls. With stray set it also pulses req_valid, mem_gnt and mem_rvalid
    // where they must be ignored.
    task automatic run_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [31:0] rdata, input int gdly, input int rdly,
                              input logic stray,
                              output int lat, output int nrsp, output logic [31:0] rd,
                              output logic flt, output logic saw_req,
                              output logic [31:0] m_addr, output logic [3:0] m_be_o,
                              output logic [31:0] m_wd_o, output logic m_we_o,
                              output logic stable, output logic busy_ok);
        int req_cycles, gnt_k, stop_k;
        lat = -1; nrsp = 0; rd = 32'd0; flt = 1'b0; saw_req = 1'b0;
        m_addr = 32'd0; m_be_o = 4'd0; m_wd_o = 32'd0; m_we_o = 1'b0;
        stable = 1'b1; busy_ok = 1'b1; req_cycles = 0; gnt_k = -1; stop_k = 60;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int k = 1; k <= stop_k; k++) begin
            @(posedge clk); #1;
            req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
            if (rsp_valid) begin
                nrsp++;
                if (lat < 0) begin
                    lat = k; rd = rsp_rdata; flt = rsp_fault; stop_k = k + 3;
                end
            end
            if ((lat < 0 || lat == k) && req_ready) busy_ok = 1'b0;
            if (mem_req) begin
                if (!saw_req) begin
                    saw_req = 1'b1; m_addr = mem_addr; m_be_o = mem_be;
                    m_wd_o = mem_wdata; m_we_o = mem_we;
                end else if (mem_addr !== m_addr || mem_be !== m_be_o ||
                             mem_wdata !== m_wd_o || mem_we !== m_we_o) begin
                    stable = 1'b0;
                end
                if (gnt_k < 0) begin
                    if (req_cycles == gdly) begin
                        mem_gnt = 1'b1; gnt_k = k;
                    end
                    req_cycles++;
                end
                if (stray) mem_rvalid = 1'b1;
            end else if (gnt_k >= 0 && k == gnt_k + 1 + rdly && !we) begin
                mem_rvalid = 1'b1; mem_rdata = rdata;
            end else if (stray && lat < 0 && gnt_k >= 0) begin
                mem_gnt = 1'b1;
            end
            if (stray && lat < 0 && !req_ready) begin
                req_valid = 1'b1; req_we = 1'($urandom); req_addr = $urandom;
                req_funct3 = 3'($urandom); req_wdata = $urandom;
            end
        end
        req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_fault !== 1'b0) begin n_bad++; $display("FAIL reset_rsp_fault: got %b want 0", rsp_fault); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({mem_req, mem_we, mem_be} !== 6'd0) begin n_bad++; $display("FAIL reset_mem_ctl: got %b want 0", {mem_req, mem_we, mem_be}); end
        n_cmp++; if ({mem_addr, mem_wdata} !== 64'd0) begin n_bad++; $display("FAIL reset_mem_data: got %h want 0", {mem_addr, mem_wdata}); end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    typedef struct {
        logic we; logic [2:0] f3; logic [31:0] addr, wdata, rdata;
        int lat; logic flt; logic [31:0] rd, maddr; logic [3:0] be; logic [31:0] wd;
    } dvec_t;

    task automatic test_directed();
        dvec_t dv[10];
        int lat, nrsp; logic [31:0] rd, ma, mw; logic flt, sr, mwe, st, bo; logic [3:0] mb;
        dv[0] = '{1'b1, 3'd2, 32'h104, 32'hDEADBEEF, 32'h0, 2, 1'b0, 32'h0, 32'h104, 4'b1111, 32'hDEADBEEF};
        dv[1] = '{1'b1, 3'd0, 32'h103, 32'h000000A5, 32'h0, 2, 1'b0, 32'h0, 32'h100, 4'b1000, 32'hA5A5A5A5};
        dv[2] = '{1'b0, 3'd0, 32'h102, 32'h0, 32'h12F45678, 3, 1'b0, 32'hFFFFFFF4, 32'h100, 4'b0100, 32'h0};
        dv[3] = '{1'b0, 3'd4, 32'h102, 32'h0, 32'h12F45678, 3, 1'b0, 32'h000000F4, 32'h100, 4'b0100, 32'h0};
        dv[4] = '{1'b0, 3'd5, 32'h102, 32'h0, 32'h12F45678, 3, 1'b0, 32'h000012F4, 32'h100, 4'b1100, 32'h0};
        dv[5] = '{1'b0, 3'd1, 32'h101, 32'h0, 32'h12F45678, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0};
        dv[6] = '{1'b1, 3'd2, 32'h102, 32'h11223344, 32'h0, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0};
        dv[7] = '{1'b1, 3'd1, 32'h102, 32'h1234ABCD, 32'h0, 2, 1'b0, 32'h0, 32'h100, 4'b1100, 32'hABCDABCD};
        dv[8] = '{1'b0, 3'd2, 32'h108, 32'h0, 32'h89ABCDEF, 3, 1'b0, 32'h89ABCDEF, 32'h108, 4'b1111, 32'h0};
        dv[9] = '{1'b0, 3'd3, 32'h100, 32'h0, 32'h89ABCDEF, 1, 1'b1, 32'h0, 32'h0, 4'b0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            run_access(dv[i].we, dv[i].f3, dv[i].addr, dv[i].wdata, dv[i].rdata, 0, 0, 1'b0,
                       lat, nrsp, rd, flt, sr, ma, mb, mw, mwe, st, bo);
            n_cmp++; if (lat !== dv[i].lat) begin n_bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, dv[i].lat); end
            n_cmp++; if (nrsp !== 1) begin n_bad++; $display("FAIL dir%0d_rsp_count: got %0d want 1", i, nrsp); end
            n_cmp++; if (flt !== dv[i].flt) begin n_bad++; $display("FAIL dir%0d_fault: got %b want %b", i, flt, dv[i].flt); end
            n_cmp++; if (rd !== dv[i].rd) begin n_bad++; $display("FAIL dir%0d_rdata: got %h want %h", i, rd, dv[i].rd); end
            n_cmp++; if (sr !== !dv[i].flt) begin n_bad++; $display("FAIL dir%0d_mem_req_seen: got %b want %b", i, sr, !dv[i].flt); end
            if (!dv[i].flt) begin
                n_cmp++; if (ma !== dv[i].maddr) begin n_bad++; $display("FAIL dir%0d_mem_addr: got %h want %h", i, ma, dv[i].maddr); end
                n_cmp++; if (mb !== dv[i].be) begin n_bad++; $display("FAIL dir%0d_mem_be: got %b want %b", i, mb, dv[i].be); end
                n_cmp++; if (mw !== dv[i].wd) begin n_bad++; $display("FAIL dir%0d_mem_wdata: got %h want %h", i, mw, dv[i].wd); end
                n_cmp++; if (mwe !== dv[i].we) begin n_bad++; $display("FAIL dir%0d_mem_we: got %b want %b", i, mwe, dv[i].we); end
            end
        end
    endtask

    task automatic test_stall();
        int lat, nrsp; logic [31:0] rd, ma, mw; logic flt, sr, mwe, st, bo; logic [3:0] mb;
        run_access(1'b0, 3'd2, 32'h200, 32'h0, 32'hCAFEF00D, 5, 2, 1'b1,
                   lat, nrsp, rd, flt, sr, ma, mb, mw, mwe, st, bo);
        n_cmp++; if (lat !== 10) begin n_bad++; $display("FAIL stall_latency: got %0d want 10", lat); end
        n_cmp++; if (nrsp !== 1) begin n_bad++; $display("FAIL stall_rsp_count: got %0d want 1", nrsp); end
        n_cmp++; if (rd !== 32'hCAFEF00D) begin n_bad++; $display("FAIL stall_rdata: got %h want cafef00d", rd); end
        n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL stall_mem_stable: got %b want 1", st); end
        n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL stall_ready_low: got %b want 1", bo); end
        n_cmp++; if (ma !== 32'h200 || mb !== 4'b1111) begin n_bad++; $display("FAIL stall_mem_addr_be: got %h/%b want 200/1111", ma, mb); end
    endtask

    task automatic test_random();
        int lat, nrsp, g, r, el; logic [31:0] rd, ma, mw, addr, wd, rdat, erd;
        logic flt, sr, mwe, st, bo, we, stray, ef; logic [3:0] mb; logic [2:0] f3;
        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); f3 = 3'($urandom_range(0, 7)); addr = $urandom;
            if ($urandom_range(0, 1) == 1) addr[1:0] = 2'b00;
            wd = $urandom; rdat = $urandom;
            g = $urandom_range(0, 3); r = $urandom_range(0, 3); stray = 1'($urandom);
            ef = m_fault(we, f3, addr);
            el = m_lat(we, f3, addr, g, r);
            erd = (ef || we) ? 32'd0 : m_rd(f3, addr, rdat);
            run_access(we, f3, addr, wd, rdat, g, r, stray, lat, nrsp, rd, flt, sr, ma, mb, mw, mwe, st, bo);
            n_cmp++; if (lat !== el) begin n_bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, el); end
            n_cmp++; if (nrsp !== 1) begin n_bad++; $display("FAIL rnd%0d_rsp_count: got %0d want 1", i, nrsp); end
            n_cmp++; if (flt !== ef) begin n_bad++; $display("FAIL rnd%0d_fault: got %b want %b", i, flt, ef); end
            n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rnd%0d_rdata: got %h want %h", i, rd, erd); end
            n_cmp++; if (sr !== !ef) begin n_bad++; $display("FAIL rnd%0d_mem_req_seen: got %b want %b", i, sr, !ef); end
            n_cmp++; if (bo !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_ready_low: got %b want 1", i, bo); end
            if (!ef) begin
                n_cmp++; if (ma !== {addr[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd%0d_mem_addr: got %h want %h", i, ma, {addr[31:2], 2'b00}); end
                n_cmp++; if (mb !== m_be(f3, addr)) begin n_bad++; $display("FAIL rnd%0d_mem_be: got %b want %b", i, mb, m_be(f3, addr)); end
                n_cmp++; if (mw !== m_wd(we, f3, wd)) begin n_bad++; $display("FAIL rnd%0d_mem_wdata: got %h want %h", i, mw, m_wd(we, f3, wd)); end
                n_cmp++; if (mwe !== we) begin n_bad++; $display("FAIL rnd%0d_mem_we: got %b want %b", i, mwe, we); end
                n_cmp++; if (st !== 1'b1) begin n_bad++; $display("FAIL rnd%0d_mem_stable: got %b want 1", i, st); end
            end
        end
    endtask

    task automatic test_reset_mid_access();
        int lat, nrsp, k; logic [31:0] rd, ma, mw, rdat; logic flt, sr, mwe, st, bo, seen_rsp; logic [3:0] mb;
        @(posedge clk); #1;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h300;
        k = 0;
        do begin
            @(posedge clk); #1; req_valid = 1'b0; k++;
        end while (!mem_req && k < 10);
        n_cmp++; if (mem_req !== 1'b1) begin n_bad++; $display("FAIL mid_issue_reached: got %b want 1", mem_req); end
        mem_gnt = 1'b1;
        @(posedge clk); #1; mem_gnt = 1'b0;
        n_cmp++; if ({req_ready, mem_req, mem_addr} !== {2'b00, 32'h300}) begin n_bad++; $display("FAIL mid_wait_r_state: got %h want 300", {req_ready, mem_req, mem_addr}); end
        #3 rst_n = 1'b0;
        #1;
        n_cmp++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_fault !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ctl: got %b%b%b want 100", req_ready, rsp_valid, rsp_fault); end
        n_cmp++; if (rsp_rdata !== 32'd0) begin n_bad++; $display("FAIL mid_reset_rdata: got %h want 0", rsp_rdata); end
        n_cmp++; if ({mem_req, mem_we, mem_be, mem_addr, mem_wdata} !== 70'd0) begin n_bad++; $display("FAIL mid_reset_mem: got %h want 0", {mem_req, mem_we, mem_be, mem_addr, mem_wdata}); end
        @(posedge clk); #1 rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h5555AAAA;
        seen_rsp = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1; mem_rvalid = 1'b0;
            if (rsp_valid) seen_rsp = 1'b1;
        end
        n_cmp++; if (seen_rsp !== 1'b0) begin n_bad++; $display("FAIL mid_late_rvalid_ignored: got %b want 0", seen_rsp); end
        rdat = $urandom;
        run_access(1'b0, 3'd2, 32'h304, 32'h0, rdat, 1, 1, 1'b0, lat, nrsp, rd, flt, sr, ma, mb, mw, mwe, st, bo);
        n_cmp++; if (lat !== 5 || nrsp !== 1) begin n_bad++; $display("FAIL mid_next_latency: got %0d/%0d want 5/1", lat, nrsp); end
        n_cmp++; if (rd !== rdat || flt !== 1'b0) begin n_bad++; $display("FAIL mid_next_rdata: got %h/%b want %h/0", rd, flt, rdat); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_stall();
        test_random();
        test_reset_mid_access();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
